// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths, ALU function codes and the ID/EX control bundle.
package cpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic              alu_src;
      logic [2:0]        alu_f;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } idex_ctrl_t;

   // Squash side effects; register numbers and operand select are left as they were.
   function automatic idex_ctrl_t bubble(input idex_ctrl_t c);
      idex_ctrl_t b;
      b            = c;
      b.valid      = 1'b0;
      b.reg_write  = 1'b0;
      b.mem_to_reg = 1'b0;
      b.mem_write  = 1'b0;
      b.alu_f      = ALU_AND;
      return b;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand source select for rs and rt: EX/MEM result, MEM/WB result or register data.
module forward_unit
   import cpu_pkg::*;
(
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [XLEN-1:0]   memwb_result,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [XLEN-1:0]   rs_data,
   input  logic [XLEN-1:0]   rt_data,
   output logic [XLEN-1:0]   rs_fwd,
   output logic [XLEN-1:0]   rt_fwd
);

   logic exmem_ok, memwb_ok;
   logic exmem_rs_hit, exmem_rt_hit, memwb_rs_hit, memwb_rt_hit;

   // $0 is hardwired, so a write to it never supplies a value.
   assign exmem_ok = exmem_reg_write && (exmem_rd != '0);
   assign memwb_ok = memwb_reg_write && (memwb_rd != '0);

   assign exmem_rs_hit = exmem_ok && (exmem_rd == ex_rs);
   assign exmem_rt_hit = exmem_ok && (exmem_rd == ex_rt);
   assign memwb_rs_hit = memwb_ok && (memwb_rd == ex_rs);
   assign memwb_rt_hit = memwb_ok && (memwb_rd == ex_rt);

   assign rs_fwd = exmem_rs_hit ? exmem_result :
                   memwb_rs_hit ? memwb_result : rs_data;
   assign rt_fwd = exmem_rt_hit ? exmem_result :
                   memwb_rt_hit ? memwb_result : rt_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Forwarding and load-use detection are built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_rs_data,
   input  logic [XLEN-1:0]   id_rt_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_alu_src,
   input  logic [2:0]        id_alu_f,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              id_mem_write,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [XLEN-1:0]   memwb_result,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_write,
   output logic [REG_AW-1:0] ex_rd,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [2:0]        alu_f,
   output logic [XLEN-1:0]   ex_store_data,
   output logic              load_use
);

   idex_ctrl_t        ctrl_d, ctrl_q;
   logic [XLEN-1:0]   rs_data_d, rs_data_q;
   logic [XLEN-1:0]   rt_data_d, rt_data_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic [XLEN-1:0]   rs_fwd, rt_fwd;

   always_comb begin
      ctrl_d    = ctrl_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      // flush beats stall; a pending load-use bubble waits for the first unstalled edge
      if (flush || (!stall && load_use)) begin
         ctrl_d = bubble(ctrl_q);
      end else if (!stall) begin
         ctrl_d.valid      = id_valid;
         ctrl_d.reg_write  = id_reg_write;
         ctrl_d.mem_to_reg = id_mem_to_reg;
         ctrl_d.mem_write  = id_mem_write;
         ctrl_d.alu_src    = id_alu_src;
         ctrl_d.alu_f      = id_alu_f;
         ctrl_d.rs         = id_rs;
         ctrl_d.rt         = id_rt;
         ctrl_d.rd         = id_rd;
         rs_data_d         = id_rs_data;
         rt_data_d         = id_rt_data;
         imm_d             = id_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
      end
   end

`ifdef ID_EX_FORWARD_EN
   forward_unit u_forward_unit (
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .ex_rs           (ctrl_q.rs),
      .ex_rt           (ctrl_q.rt),
      .rs_data         (rs_data_q),
      .rt_data         (rt_data_q),
      .rs_fwd          (rs_fwd),
      .rt_fwd          (rt_fwd)
   );

   assign load_use = ctrl_q.valid && ctrl_q.mem_to_reg && id_valid && (ctrl_q.rd != '0) &&
                     ((ctrl_q.rd == id_rs) || (ctrl_q.rd == id_rt));
`else
   assign rs_fwd   = rs_data_q;
   assign rt_fwd   = rt_data_q;
   assign load_use = 1'b0;

   logic unused_fwd;
   assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd,
                         memwb_result, ctrl_q.rs, ctrl_q.rt};
`endif

   assign ex_valid      = ctrl_q.valid;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_rd         = ctrl_q.rd;
   assign alu_f         = ctrl_q.alu_f;
   assign alu_a         = rs_fwd;
   assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations adapt to whether ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        id_valid = 0, id_alu_src = 0, id_reg_write = 0, id_mem_to_reg = 0;
   logic        id_mem_write = 0, stall = 0, flush = 0;
   logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
   logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
   logic [2:0]  id_alu_f = 0;
   logic        exmem_reg_write = 0, memwb_reg_write = 0;
   logic [4:0]  exmem_rd = 0, memwb_rd = 0;
   logic [31:0] exmem_result = 0, memwb_result = 0;
   logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, load_use;
   logic [4:0]  ex_rd;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_f;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_rs_data (id_rs_data),
      .id_rt_data (id_rt_data), .id_imm (id_imm), .id_rs (id_rs), .id_rt (id_rt), .id_rd (id_rd),
      .id_alu_src (id_alu_src), .id_alu_f (id_alu_f), .id_reg_write (id_reg_write),
      .id_mem_to_reg (id_mem_to_reg), .id_mem_write (id_mem_write), .stall (stall),
      .flush (flush), .exmem_reg_write (exmem_reg_write), .exmem_rd (exmem_rd),
      .exmem_result (exmem_result), .memwb_reg_write (memwb_reg_write), .memwb_rd (memwb_rd),
      .memwb_result (memwb_result), .ex_valid (ex_valid), .ex_reg_write (ex_reg_write),
      .ex_mem_to_reg (ex_mem_to_reg), .ex_mem_write (ex_mem_write), .ex_rd (ex_rd),
      .alu_a (alu_a), .alu_b (alu_b), .alu_f (alu_f), .ex_store_data (ex_store_data),
      .load_use (load_use)
   );

   typedef struct {
      logic        valid, alu_src, rw, mtr, mw, stl;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [2:0]  f;
      logic        xrw, wrw;
      logic [4:0]  xrd, wrd;
      logic [31:0] xres, wres;
      logic        e_valid, e_rw, e_mtr, e_mw;
      logic [4:0]  e_rd;
      logic [2:0]  e_f;
      logic [31:0] e_a, e_b, e_sd, n_a, n_b, n_sd;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk_in(input logic valid, input logic [31:0] rs_data, rt_data, imm,
                                  input logic [4:0] rs, rt, rd, input logic alu_src,
                                  input logic [2:0] f, input logic rw, mtr, mw, stl);
      vec_t v;
      v = '{default: '0};
      v.valid = valid; v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm;
      v.rs = rs; v.rt = rt; v.rd = rd; v.alu_src = alu_src; v.f = f;
      v.rw = rw; v.mtr = mtr; v.mw = mw; v.stl = stl;
      return v;
   endfunction

   function automatic vec_t fw(input vec_t vi, input logic xrw, input logic [4:0] xrd,
                               input logic [31:0] xres, input logic wrw, input logic [4:0] wrd,
                               input logic [31:0] wres);
      vec_t v;
      v = vi;
      v.xrw = xrw; v.xrd = xrd; v.xres = xres; v.wrw = wrw; v.wrd = wrd; v.wres = wres;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input logic valid, rw, mtr, mw,
                               input logic [4:0] rd, input logic [2:0] f,
                               input logic [31:0] a, b, sd, na, nb, nsd);
      vec_t v;
      v = vi;
      v.e_valid = valid; v.e_rw = rw; v.e_mtr = mtr; v.e_mw = mw; v.e_rd = rd; v.e_f = f;
      v.e_a = a; v.e_b = b; v.e_sd = sd; v.n_a = na; v.n_b = nb; v.n_sd = nsd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive_id(input logic valid, input logic [31:0] rs_data, rt_data, imm,
                           input logic [4:0] rs, rt, rd, input logic alu_src,
                           input logic [2:0] f, input logic rw, mtr, mw);
      id_valid = valid; id_rs_data = rs_data; id_rt_data = rt_data; id_imm = imm;
      id_rs = rs; id_rt = rt; id_rd = rd; id_alu_src = alu_src; id_alu_f = f;
      id_reg_write = rw; id_mem_to_reg = mtr; id_mem_write = mw;
   endtask

   task automatic set_fwd(input logic xrw, input logic [4:0] xrd, input logic [31:0] xres,
                          input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
      exmem_reg_write = xrw; exmem_rd = xrd; exmem_result = xres;
      memwb_reg_write = wrw; memwb_rd = wrd; memwb_result = wres;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ex_valid"}, ex_valid, 0);
      chk({tag, " ex_reg_write"}, ex_reg_write, 0);
      chk({tag, " ex_mem_to_reg"}, ex_mem_to_reg, 0);
      chk({tag, " ex_mem_write"}, ex_mem_write, 0);
      chk({tag, " ex_rd"}, ex_rd, 0);
      chk({tag, " alu_f"}, alu_f, 0);
      chk({tag, " alu_a"}, alu_a, 0);
      chk({tag, " alu_b"}, alu_b, 0);
      chk({tag, " ex_store_data"}, ex_store_data, 0);
      chk({tag, " load_use"}, load_use, 0);
   endtask

   initial begin
      vecs[0] = ex(mk_in(1, 5, 7, 0, 1, 2, 4, 0, 3'b010, 1, 0, 0, 0),
                   1, 1, 0, 0, 4, 3'b010, 5, 7, 7, 5, 7, 7);
      vecs[1] = ex(mk_in(1, 9, 'h33, 'hFFFF_FFFC, 5, 6, 7, 1, 3'b010, 1, 0, 1, 0),
                   1, 1, 0, 1, 7, 3'b010, 9, 'hFFFF_FFFC, 'h33, 9, 'hFFFF_FFFC, 'h33);
      vecs[2] = ex(fw(mk_in(1, 'h100, 'h200, 'h8, 3, 4, 9, 0, 3'b110, 1, 0, 0, 0),
                      1, 3, 'h11, 1, 3, 'h22),
                   1, 1, 0, 0, 9, 3'b110, 'h11, 'h200, 'h200, 'h100, 'h200, 'h200);
      vecs[3] = ex(fw(mk_in(1, 'hDEAD, 'hBEEF, 'h1, 3, 3, 15, 1, 3'b001, 0, 1, 1, 1),
                      0, 3, 'h11, 1, 3, 'h22),
                   1, 1, 0, 0, 9, 3'b110, 'h22, 'h200, 'h200, 'h100, 'h200, 'h200);
      vecs[4] = ex(fw(mk_in(1, 'hDEAD, 'hBEEF, 'h1, 3, 3, 15, 1, 3'b001, 0, 1, 1, 1),
                      1, 0, 'h11, 0, 3, 'h22),
                   1, 1, 0, 0, 9, 3'b110, 'h100, 'h200, 'h200, 'h100, 'h200, 'h200);
      vecs[5] = ex(fw(mk_in(1, 'hDEAD, 'hBEEF, 'h1, 3, 3, 15, 1, 3'b001, 0, 1, 1, 1),
                      1, 4, 'h44, 1, 4, 'h55),
                   1, 1, 0, 0, 9, 3'b110, 'h100, 'h44, 'h44, 'h100, 'h200, 'h200);
      vecs[6] = ex(fw(mk_in(1, 'hDEAD, 'hBEEF, 'h1, 3, 3, 15, 1, 3'b001, 0, 1, 1, 1),
                      0, 4, 'h44, 1, 4, 'h55),
                   1, 1, 0, 0, 9, 3'b110, 'h100, 'h55, 'h55, 'h100, 'h200, 'h200);
      vecs[7] = ex(fw(mk_in(1, 'hA, 'hB, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0),
                      1, 0, 'h99, 1, 0, 'h98),
                   1, 0, 0, 0, 0, 3'b111, 'hA, 'hB, 'hB, 'hA, 'hB, 'hB);

      // Asynchronous reset asserted between clock edges.
      #3 rst_n = 1'b0;
      #1 chk_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive_id(vecs[i].valid, vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm, vecs[i].rs,
                  vecs[i].rt, vecs[i].rd, vecs[i].alu_src, vecs[i].f, vecs[i].rw, vecs[i].mtr,
                  vecs[i].mw);
         stall = vecs[i].stl;
         set_fwd(0, 0, 0, 0, 0, 0);
         @(posedge clk);
         #1 set_fwd(vecs[i].xrw, vecs[i].xrd, vecs[i].xres, vecs[i].wrw, vecs[i].wrd,
                    vecs[i].wres);
         #1;
         chk($sformatf("v%0d ex_valid", i), ex_valid, vecs[i].e_valid);
         chk($sformatf("v%0d ex_reg_write", i), ex_reg_write, vecs[i].e_rw);
         chk($sformatf("v%0d ex_mem_to_reg", i), ex_mem_to_reg, vecs[i].e_mtr);
         chk($sformatf("v%0d ex_mem_write", i), ex_mem_write, vecs[i].e_mw);
         chk($sformatf("v%0d ex_rd", i), ex_rd, vecs[i].e_rd);
         chk($sformatf("v%0d alu_f", i), alu_f, vecs[i].e_f);
         chk($sformatf("v%0d alu_a", i), alu_a, FWD ? vecs[i].e_a : vecs[i].n_a);
         chk($sformatf("v%0d alu_b", i), alu_b, FWD ? vecs[i].e_b : vecs[i].n_b);
         chk($sformatf("v%0d ex_store_data", i), ex_store_data,
             FWD ? vecs[i].e_sd : vecs[i].n_sd);
         chk($sformatf("v%0d load_use", i), load_use, 0);
      end

      // Load followed by a dependent instruction.
      @(negedge clk);
      stall = 0;
      set_fwd(0, 0, 0, 0, 0, 0);
      drive_id(1, 'h1000, 0, 4, 1, 2, 8, 1, 3'b010, 1, 1, 0);
      @(posedge clk);
      #1;
      chk("ld ex_mem_to_reg", ex_mem_to_reg, 1);
      chk("ld ex_rd", ex_rd, 8);
      chk("ld load_use", load_use, 0);
      @(negedge clk);
      drive_id(1, 'h77, 'h66, 0, 8, 2, 10, 0, 3'b001, 1, 0, 0);
      #1 chk("lu detect", load_use, FWD);
      @(posedge clk);
      #1;
      chk("lu bubble ex_valid", ex_valid, !FWD);
      chk("lu bubble ex_reg_write", ex_reg_write, !FWD);
      chk("lu bubble alu_f", alu_f, FWD ? 3'b000 : 3'b001);
      chk("lu bubble ex_rd", ex_rd, FWD ? 8 : 10);
      chk("lu release", load_use, 0);
      @(negedge clk);
      set_fwd(0, 0, 0, 1, 8, 'hABC);
      @(posedge clk);
      #1;
      chk("lu dep ex_valid", ex_valid, 1);
      chk("lu dep ex_rd", ex_rd, 10);
      chk("lu dep alu_a", alu_a, FWD ? 'hABC : 'h77);

      // Three stalled edges with changing decode inputs.
      @(negedge clk);
      set_fwd(0, 0, 0, 0, 0, 0);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         drive_id(k[0], 'h500 + k, 'h600 + k, k, 5'd20 + 5'(k), 5'd21, 5'd22 + 5'(k), 1,
                  3'(k + 4), 0, 0, 1);
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d ex_valid", k), ex_valid, 1);
         chk($sformatf("stall%0d ex_reg_write", k), ex_reg_write, 1);
         chk($sformatf("stall%0d ex_mem_write", k), ex_mem_write, 0);
         chk($sformatf("stall%0d ex_rd", k), ex_rd, 10);
         chk($sformatf("stall%0d alu_f", k), alu_f, 3'b001);
         chk($sformatf("stall%0d alu_a", k), alu_a, 'h77);
         chk($sformatf("stall%0d alu_b", k), alu_b, 'h66);
         @(negedge clk);
      end

      // Flush together with stall squashes the held instruction.
      flush = 1;
      drive_id(1, 1, 2, 3, 1, 2, 3, 0, 3'b010, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("flush ex_valid", ex_valid, 0);
      chk("flush ex_reg_write", ex_reg_write, 0);
      chk("flush alu_f", alu_f, 3'b000);
      chk("flush ex_rd", ex_rd, 10);

      // Reset arriving during a stall clears state without waiting for an edge.
      @(negedge clk);
      flush = 0;
      stall = 0;
      drive_id(1, 5, 3, 0, 1, 2, 12, 0, 3'b111, 1, 0, 0);
      @(posedge clk);
      #1 chk("pre-reset ex_valid", ex_valid, 1);
      @(negedge clk);
      stall = 1;
      #2 rst_n = 1'b0;
      #1 chk_zero("midstall reset");
      @(negedge clk);
      rst_n = 1'b1;
      stall = 0;
      id_valid = 0;
      @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
